led_mode_ctrl: RTL and testbench
================================

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500000: consecutive stable synchronized-input cycles required to accept a button level change; range 2..2^24-1.
REQ-002 Parameter LONG_CYC, default 50000000: debounced hold duration, in cycles, that counts as a long press.
REQ-003 Parameter SLOW_HALF, default 25000000: half-period, in cycles, of the slow blink.
REQ-004 Parameter FAST_HALF, default 5000000: half-period, in cycles, of the fast blink; FAST_HALF < SLOW_HALF.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 btn  input  1  raw asynchronous button, 1 = pressed.
REQ-008 led  output 1  registered LED drive, 1 = lit.
REQ-009 mode  output 2  registered current mode: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST.
REQ-010 press_pulse  output 1  registered one-cycle strobe per accepted debounced press.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debouncer SHALL update its debounced level only after the synchronized input has differed from that level for DEBOUNCE_CYC consecutive cycles.
REQ-013 Any cycle in which the synchronized input equals the debounced level SHALL clear the debounce counter, so glitches shorter than DEBOUNCE_CYC are ignored.
REQ-014 press_pulse SHALL be high for exactly one cycle, in the cycle after the debounced level rises.
REQ-015 Mode sequence on each advance: OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF; the transition from BLINK_FAST to OFF is the wrap.
REQ-016 The mode register SHALL take its new value one cycle after the triggering event.
REQ-017 In OFF, led SHALL be 0; in ON, led SHALL be 1.
REQ-018 In the blink modes, led SHALL toggle every SLOW_HALF or FAST_HALF cycles.
REQ-019 On entry to either blink mode, the blink counter SHALL clear and led SHALL start at 1.
REQ-020 led SHALL be registered and SHALL update in the same cycle as mode.
REQ-021 The blink counter SHALL be wide enough for SLOW_HALF-1 and SHALL wrap to 0 at the half-period end.
REQ-022 The hold counter SHALL saturate at LONG_CYC and never wrap.
REQ-023 A new debounced press arriving in the same cycle as a blink toggle SHALL take priority: the mode change applies and the blink phase restarts per REQ-019.

Reset
REQ-024 rst SHALL immediately clear every flop without waiting for a clock edge: synchronizer, debounced level (0 = released), all counters, mode = OFF, led = 0, press_pulse = 0.
REQ-025 Reset asserted mid-press SHALL discard the press.
REQ-026 After reset deasserts, a button still held SHALL count as a new press only after it is debounced high again from the released state.

Configuration
REQ-027 Macro LED_MODE_LONG_PRESS_EN defined: the mode advances on debounced release when hold < LONG_CYC.
REQ-028 Macro LED_MODE_LONG_PRESS_EN defined: when the hold reaches LONG_CYC, mode SHALL go to OFF once, and the subsequent release SHALL be ignored.
REQ-029 Macro LED_MODE_LONG_PRESS_EN undefined: the mode advances on press_pulse; no hold counter or LONG_CYC logic is built.

Structure
REQ-030 Package led_mode_pkg SHALL hold the mode enum (MODE_OFF, MODE_ON, MODE_SLOW, MODE_FAST) and the 2-bit mode width constant.
REQ-031 Sub-module btn_debounce SHALL contain the synchronizer and debouncer.
REQ-032 btn_debounce SHALL be parameterized by DEBOUNCE_CYC and SHALL output the debounced level and registered rise and fall strobes.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20, SLOW_HALF=8, FAST_HALF=2)
REQ-033 Glitch rejection: btn pulses high for 3 cycles -> press_pulse stays 0 and mode stays OFF.
REQ-034 Short press with the macro undefined: btn held high for 10 cycles -> exactly one press_pulse and mode=1, led=1; four presses -> mode returns to 0, led=0.
REQ-035 Short press with the macro defined: hold 10 cycles, then release -> mode advances only after the debounced release; no advance at the press.
REQ-036 Long press with the macro defined: from mode=2, hold 30 cycles -> mode=0 when the hold count reaches 20; after release, mode stays 0.
REQ-037 Blink: mode=2 -> led pattern of 8 cycles at 1, 8 at 0, repeating; advance to mode=3 -> led restarts at 1 with 2/2 cycle toggling.
REQ-038 Reset: assert rst asynchronously mid-blink with btn held -> outputs 0 and mode=0 immediately; after deassert with btn still high -> mode=1 after the debounce latency (macro undefined).

Source files
------------

// File: rtl/led_mode_pkg.sv
// led_mode_pkg: shared types and constants for the LED mode controller.
//   mode_e    - operating mode, encoded to match the 2-bit mode output
//   MODE_W    - width of the mode encoding
//   next_mode - mode that follows a given mode on each advance (wraps FAST -> OFF)
package led_mode_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e i_mode);
    mode_e w_next;
    case (i_mode)
      MODE_OFF:  w_next = MODE_ON;
      MODE_ON:   w_next = MODE_SLOW;
      MODE_SLOW: w_next = MODE_FAST;
      default:   w_next = MODE_OFF;
    endcase
    return w_next;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a counting debouncer.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_btn        : raw asynchronous button (1 = pressed)
//   o_level      : debounced level (0 = released after reset)
//   o_rise       : registered one-cycle strobe, set together with a 0->1 level change
//   o_fall       : registered one-cycle strobe, set together with a 1->0 level change
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // Counter only needs to reach DEBOUNCE_CYC-1; DEBOUNCE_CYC >= 2 keeps CNT_W >= 1.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  // Synchronizer, debounce counter and edge strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        // Any agreeing sample restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: single-button LED mode controller (OFF -> ON -> SLOW -> FAST -> OFF).
//   clk, rst    : clock, asynchronous active-high reset
//   btn         : raw asynchronous button (1 = pressed)
//   led         : registered LED drive (1 = lit)
//   mode        : registered current mode (0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST)
//   press_pulse : registered one-cycle strobe per accepted debounced press
// Build option: define LED_MODE_LONG_PRESS_EN to advance on short-press release and
// force OFF on a long hold; otherwise the mode advances on each debounced press.
module led_mode_ctrl
  import led_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned LONG_CYC     = 50000000,
  parameter int unsigned SLOW_HALF    = 25000000,
  parameter int unsigned FAST_HALF    = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  output logic              led,
  output logic [MODE_W-1:0] mode,
  output logic              press_pulse
);

  localparam int unsigned BLINK_W = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;

  logic               w_level;
  logic               w_rise;
  logic               w_fall;
  logic               w_advance;
  logic               w_long_hit;
  logic [BLINK_W-1:0] w_half_m1;

  mode_e              r_mode;
  logic               r_led;
  logic               r_press;
  logic [BLINK_W-1:0] r_blink_cnt;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_btn  (btn),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

`ifdef LED_MODE_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

  logic [HOLD_W-1:0] r_hold;

  // Hold duration of the current debounced press, saturating at LONG_CYC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_fall) begin
      r_hold <= '0;
    end else if (w_level && (r_hold != HOLD_W'(LONG_CYC))) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  // Fires once, on the cycle the hold count steps onto LONG_CYC.
  assign w_long_hit = w_level && (r_hold == HOLD_W'(LONG_CYC - 1));
  // A release that follows a long hold has already acted, so it is ignored.
  assign w_advance  = w_fall && (r_hold != HOLD_W'(LONG_CYC));
`else
  // Level, fall strobe and hold limit only matter to the long-press build.
  logic w_unused;
  assign w_unused   = &{1'b0, w_level, w_fall, LONG_CYC[0]};
  assign w_long_hit = 1'b0;
  assign w_advance  = w_rise;
`endif

  assign w_half_m1 = (r_mode == MODE_SLOW) ? BLINK_W'(SLOW_HALF - 1) : BLINK_W'(FAST_HALF - 1);

  // Mode FSM with registered LED and press strobe; mode changes outrank blink toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_OFF;
      r_led       <= 1'b0;
      r_press     <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_press <= w_rise;
      if (w_long_hit) begin
        r_mode      <= MODE_OFF;
        r_led       <= 1'b0;
        r_blink_cnt <= '0;
      end else if (w_advance) begin
        r_mode      <= next_mode(r_mode);
        // ON and both blink modes start lit; only OFF is dark.
        r_led       <= (next_mode(r_mode) != MODE_OFF);
        r_blink_cnt <= '0;
      end else if ((r_mode == MODE_SLOW) || (r_mode == MODE_FAST)) begin
        if (r_blink_cnt == w_half_m1) begin
          r_blink_cnt <= '0;
          r_led       <= ~r_led;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  assign led         = r_led;
  assign mode        = r_mode;
  assign press_pulse = r_press;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: randomized and directed stimulus for led_mode_ctrl, checked every
// cycle against a behavioural model (sample-window debounce, phase-based blink).
module tb_led_mode_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int SLOW = 8;
  localparam int FAST = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       led;
  logic [1:0] mode;
  logic       press_pulse;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic m_s1, m_s2, m_db, m_rise, m_fall, m_led, m_press;
  bit   m_hist[$];
  int   m_hold, m_mode, m_phase;

  led_mode_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LONG),
    .SLOW_HALF   (SLOW),
    .FAST_HALF   (FAST)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .led        (led),
    .mode       (mode),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_led();
    case (m_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_phase / SLOW) % 2) == 0;
      default: return ((m_phase / FAST) % 2) == 0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_rise = 0; m_fall = 0;
    m_led = 0; m_press = 0; m_hold = 0; m_mode = 0; m_phase = 0;
    m_hist.delete();
  endtask

  // Advance the model by one rising edge, using values that held before the edge.
  task automatic model_step();
    logic pre_db, pre_rise, pre_fall;
    bit   adv, off, all_diff;
    pre_db   = m_db;
    pre_rise = m_rise;
    pre_fall = m_fall;
    adv      = 0;
    off      = 0;
    m_press  = pre_rise;
`ifdef LED_MODE_LONG_PRESS_EN
    if (pre_db && m_hold < LONG) begin
      m_hold++;
      if (m_hold == LONG) off = 1;
    end
    if (pre_fall) begin
      adv    = (m_hold < LONG);
      m_hold = 0;
    end
`else
    adv = pre_rise;
    if (pre_db || pre_fall) m_hold = 0;
`endif
    if (off) begin
      m_mode  = 0;
      m_phase = 0;
    end else if (adv) begin
      m_mode  = (m_mode + 1) % 4;
      m_phase = 0;
    end else begin
      m_phase++;
    end
    m_led = model_led();
    // Debounced level flips once the last DEB synchronized samples all disagree with it.
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    m_rise = 0;
    m_fall = 0;
    if (m_hist.size() == DEB) begin
      all_diff = 1;
      foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db   = ~m_db;
        m_rise = m_db;
        m_fall = ~m_db;
        m_hist.delete();
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic cycle(input logic b);
    btn = b;
    @(posedge clk);
    model_step();
    #1;
    check("led", 32'(led), 32'(m_led));
    check("mode", 32'(mode), 32'(m_mode));
    check("press_pulse", 32'(press_pulse), 32'(m_press));
    @(negedge clk);
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) cycle(b);
  endtask

  task automatic press();
    hold(1'b1, 10);
    hold(1'b0, 10);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    btn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_led", 32'(led), 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_press", 32'(press_pulse), 32'd0);
    rst = 1'b0;

    // Glitch shorter than the debounce window is ignored.
    hold(1'b1, 3);
    hold(1'b0, 10);
    check("glitch_mode", 32'(mode), 32'd0);

    // Single press: exactly one strobe.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(i < 10 ? 1'b1 : 1'b0);
      if (press_pulse) pulses++;
    end
    check("press_count", 32'(pulses), 32'd1);
    check("press_mode", 32'(mode), 32'd1);
    check("press_led", 32'(led), 32'd1);

    // Into slow blink, watch it, then fast blink, then wrap to OFF.
    press();
    check("slow_mode", 32'(mode), 32'd2);
    hold(1'b0, 40);
    press();
    check("fast_mode", 32'(mode), 32'd3);
    hold(1'b0, 12);
    press();
    check("wrap_mode", 32'(mode), 32'd0);
    check("wrap_led", 32'(led), 32'd0);

`ifdef LED_MODE_LONG_PRESS_EN
    // Long hold from slow blink forces OFF and the release is ignored.
    press();
    press();
    check("long_pre_mode", 32'(mode), 32'd2);
    hold(1'b1, 30);
    check("long_hold_mode", 32'(mode), 32'd0);
    hold(1'b0, 12);
    check("long_release_mode", 32'(mode), 32'd0);
`endif

    // Randomized button activity.
    for (int s = 0; s < 150; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      hold(lvl, len);
    end

    // Asynchronous reset mid-blink with the button held.
    hold(1'b0, 12);
    while (m_mode != 2) press();
    hold(1'b0, 5);
    btn = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_press", 32'(press_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 12);
`ifdef LED_MODE_LONG_PRESS_EN
    check("post_rst_mode", 32'(mode), 32'd0);
`else
    check("post_rst_mode", 32'(mode), 32'd1);
`endif
    hold(1'b0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
